// File: rtl/pwm_multi_dt.sv
// pwm_multi_dt
//   Multi-channel PWM generator with complementary outputs and dead-time.
//   One shared period counter (edge- or center-aligned) drives CHANNELS
//   comparators; each channel feeds a small FSM that inserts dead-time
//   between the high-side and low-side drives.
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   duty_in       duty per channel, channel k at [k*WIDTH +: WIDTH]
//   duty_wr       per-channel write strobe into the shadow duty register
//   center_in     0 = edge-aligned, 1 = center-aligned (loaded at boundary)
//   dead_time_in  dead-time in cycles (loaded at boundary)
//   pwm_hi        high-side drive, registered
//   pwm_lo        low-side drive, registered
//   period_start  registered flag of cnt==0; it lines up with the pwm
//                 outputs, which also lag the counter by one cycle
//
// Duty, mode and dead-time are double-buffered: writes land in shadow
// registers and are copied to the active set in the last cycle of a period,
// so a period is never generated with a mix of old and new settings.
module pwm_multi_dt #(
  parameter int WIDTH    = 11,
  parameter int CHANNELS = 4,
  parameter int DT_W     = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic [CHANNELS-1:0]       duty_wr,
  input  logic                      center_in,
  input  logic [DT_W-1:0]           dead_time_in,
  output logic [CHANNELS-1:0]       pwm_hi,
  output logic [CHANNELS-1:0]       pwm_lo,
  output logic                      period_start
);

  localparam logic [WIDTH-1:0] MAX    = '1;
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [DT_W-1:0]  ONE_DT = DT_W'(1);

  typedef enum logic [1:0] {
    LO    = 2'd0,
    DT_HI = 2'd1,
    HI    = 2'd2,
    DT_LO = 2'd3
  } ch_state_t;

  logic [WIDTH-1:0] cnt_p0;
  logic             dir_dn_p0;
  logic             center_p0;
  logic [DT_W-1:0]  dead_time_p0;
  logic [WIDTH-1:0] shadow_p0 [CHANNELS];
  logic [WIDTH-1:0] active_p0 [CHANNELS];

  logic [WIDTH-1:0] cnt_nxt;
  logic             dir_dn_nxt;
  logic             boundary_p0;
  logic [CHANNELS-1:0] raw_p0;

  ch_state_t        state_p1  [CHANNELS];
  ch_state_t        state_nxt [CHANNELS];
  logic [DT_W-1:0]  dtc_p1    [CHANNELS];
  logic [DT_W-1:0]  dtc_nxt   [CHANNELS];

  // ---- Stage p0: period counter, shadow/active registers, comparators ----

  // Last cycle of a period: the next counter value is 0 in both modes.
  assign boundary_p0 = (!center_p0 && (cnt_p0 == MAX)) ||
                       ( center_p0 && dir_dn_p0 && (cnt_p0 == ONE));

  always_comb begin
    cnt_nxt    = cnt_p0 + ONE;
    dir_dn_nxt = dir_dn_p0;
    if (!center_p0) begin
      cnt_nxt    = (cnt_p0 == MAX) ? '0 : cnt_p0 + ONE;
      dir_dn_nxt = 1'b0;
    end else if (!dir_dn_p0) begin
      // Turn around at the top without repeating MAX.
      if (cnt_p0 == MAX) begin
        cnt_nxt    = MAX - ONE;
        dir_dn_nxt = 1'b1;
      end
    end else begin
      // Count down to 1, then 0 restarts the ramp going up.
      if (cnt_p0 == ONE) begin
        cnt_nxt    = '0;
        dir_dn_nxt = 1'b0;
      end else begin
        cnt_nxt = cnt_p0 - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0       <= '0;
      dir_dn_p0    <= 1'b0;
      center_p0    <= 1'b0;
      dead_time_p0 <= '0;
      period_start <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        shadow_p0[k] <= '0;
        active_p0[k] <= '0;
      end
    end else begin
      cnt_p0       <= cnt_nxt;
      dir_dn_p0    <= dir_dn_nxt;
      period_start <= (cnt_p0 == '0);
      if (boundary_p0) begin
        center_p0    <= center_in;
        dead_time_p0 <= dead_time_in;
        for (int k = 0; k < CHANNELS; k++) begin
          active_p0[k] <= shadow_p0[k];
        end
      end
      // A write in the boundary cycle itself lands in the shadow only;
      // the active copy above still takes the previous shadow value.
      for (int k = 0; k < CHANNELS; k++) begin
        if (duty_wr[k]) begin
          shadow_p0[k] <= duty_in[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      raw_p0[k] = (cnt_p0 < active_p0[k]);
    end
  end

  // ---- Stage p1: per-channel dead-time FSM and registered drives ----

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      state_nxt[k] = state_p1[k];
      dtc_nxt[k]   = dtc_p1[k];
      case (state_p1[k])
        LO: begin
          if (raw_p0[k]) begin
            if (dead_time_p0 == '0) begin
              state_nxt[k] = HI;
            end else begin
              state_nxt[k] = DT_HI;
              dtc_nxt[k]   = ONE_DT;
            end
          end
        end
        HI: begin
          if (!raw_p0[k]) begin
            if (dead_time_p0 == '0) begin
              state_nxt[k] = LO;
            end else begin
              state_nxt[k] = DT_LO;
              dtc_nxt[k]   = ONE_DT;
            end
          end
        end
        DT_HI: begin
          // Pulse ended before the dead-time ran out: never drive high.
          if (!raw_p0[k]) begin
            state_nxt[k] = LO;
          end else if (dtc_p1[k] >= dead_time_p0) begin
            state_nxt[k] = HI;
          end else begin
            dtc_nxt[k] = dtc_p1[k] + ONE_DT;
          end
        end
        default: begin
          if (raw_p0[k]) begin
            state_nxt[k] = HI;
          end else if (dtc_p1[k] >= dead_time_p0) begin
            state_nxt[k] = LO;
          end else begin
            dtc_nxt[k] = dtc_p1[k] + ONE_DT;
          end
        end
      endcase
    end
  end

  // Drives are decoded from the next state into flops so that the pins
  // come straight from registers and can never both be high.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_p1[k] <= DT_LO;
        dtc_p1[k]   <= ONE_DT;
      end
      pwm_hi <= '0;
      pwm_lo <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_p1[k] <= state_nxt[k];
        dtc_p1[k]   <= dtc_nxt[k];
        pwm_hi[k]   <= (state_nxt[k] == HI);
        pwm_lo[k]   <= (state_nxt[k] == LO);
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_dt.sv
// tb_pwm_multi_dt
//   Bench for pwm_multi_dt at WIDTH=4, CHANNELS=2, DT_W=3.
//   A cycle model predicts {pwm_hi, pwm_lo, period_start} after every clock
//   edge and queues it; a negedge monitor pops and compares. Directed
//   windows additionally count high/low/dead cycles per period.
module tb_pwm_multi_dt;

  localparam int W   = 4;
  localparam int CH  = 2;
  localparam int DW  = 3;
  localparam int MAX = 15;
  localparam int S_LO = 0, S_DH = 1, S_HI = 2, S_DL = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*W-1:0] duty_in;
  logic [CH-1:0]   duty_wr;
  logic            center_in;
  logic [DW-1:0]   dead_time_in;
  logic [CH-1:0]   pwm_hi;
  logic [CH-1:0]   pwm_lo;
  logic            period_start;

  int n_chk  = 0;
  int n_pass = 0;

  logic [4:0] sb_q [$];

  // model state
  int m_cnt, m_dir_dn, m_center, m_dt;
  bit m_ps;
  int m_sh [CH];
  int m_act [CH];
  int m_st [CH];
  int m_dtc [CH];

  // per-window accumulators
  int a_hi [CH];
  int a_lo [CH];
  int a_bl [CH];
  int a_ps;
  int n_both_hi = 0;
  bit last_ps;

  pwm_multi_dt #(.WIDTH(W), .CHANNELS(CH), .DT_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .duty_in      (duty_in),
    .duty_wr      (duty_wr),
    .center_in    (center_in),
    .dead_time_in (dead_time_in),
    .pwm_hi       (pwm_hi),
    .pwm_lo       (pwm_lo),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk) begin : sb_mon
    logic [4:0] e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("sb_out", int'({pwm_hi, pwm_lo, period_start}), int'(e));
    end
  end

  task automatic model_step();
    bit raw, bnd;
    logic [CH-1:0] eh, el;
    if (rst) begin
      m_cnt = 0; m_dir_dn = 0; m_center = 0; m_dt = 0; m_ps = 1'b0;
      for (int k = 0; k < CH; k++) begin
        m_sh[k] = 0; m_act[k] = 0; m_st[k] = S_DL; m_dtc[k] = 1;
      end
    end else begin
      bnd = (m_center == 0 && m_cnt == MAX) ||
            (m_center == 1 && m_dir_dn == 1 && m_cnt == 1);
      for (int k = 0; k < CH; k++) begin
        raw = (m_cnt < m_act[k]);
        case (m_st[k])
          S_LO: if (raw) begin
                  if (m_dt == 0) m_st[k] = S_HI;
                  else begin m_st[k] = S_DH; m_dtc[k] = 1; end
                end
          S_HI: if (!raw) begin
                  if (m_dt == 0) m_st[k] = S_LO;
                  else begin m_st[k] = S_DL; m_dtc[k] = 1; end
                end
          S_DH: if (!raw) m_st[k] = S_LO;
                else if (m_dtc[k] >= m_dt) m_st[k] = S_HI;
                else m_dtc[k]++;
          default: if (raw) m_st[k] = S_HI;
                   else if (m_dtc[k] >= m_dt) m_st[k] = S_LO;
                   else m_dtc[k]++;
        endcase
      end
      m_ps = (m_cnt == 0);
      if (m_center == 0) begin
        m_cnt = (m_cnt == MAX) ? 0 : m_cnt + 1;
      end else if (m_dir_dn == 0) begin
        if (m_cnt == MAX) begin m_cnt = MAX - 1; m_dir_dn = 1; end
        else m_cnt++;
      end else begin
        if (m_cnt == 1) begin m_cnt = 0; m_dir_dn = 0; end
        else m_cnt--;
      end
      if (bnd) begin
        m_center = int'(center_in);
        m_dt     = int'(dead_time_in);
        for (int k = 0; k < CH; k++) m_act[k] = m_sh[k];
      end
      for (int k = 0; k < CH; k++)
        if (duty_wr[k]) m_sh[k] = int'(duty_in[k*W +: W]);
    end
    for (int k = 0; k < CH; k++) begin
      eh[k] = (m_st[k] == S_HI);
      el[k] = (m_st[k] == S_LO);
    end
    sb_q.push_back({eh, el, m_ps});
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < CH; k++) begin
      a_hi[k] += int'(pwm_hi[k]);
      a_lo[k] += int'(pwm_lo[k]);
      a_bl[k] += int'(!pwm_hi[k] && !pwm_lo[k]);
    end
    if ((pwm_hi & pwm_lo) != '0) n_both_hi++;
    a_ps += int'(period_start);
    last_ps = period_start;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    for (int k = 0; k < CH; k++) begin
      a_hi[k] = 0; a_lo[k] = 0; a_bl[k] = 0;
    end
    a_ps = 0;
  endtask

  task automatic align();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < 64);
    check_val("align", int'(period_start), 1);
  endtask

  task automatic wr_duty(input int k, input int v);
    duty_in[k*W +: W] = W'(v);
    duty_wr[k] = 1'b1;
    step();
    duty_wr[k] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; duty_in = '0; duty_wr = '0; center_in = 1'b0; dead_time_in = '0;
    clr();
    steps(3);
    check_val("rst_hi", int'(pwm_hi), 0);
    check_val("rst_lo", int'(pwm_lo), 0);
    check_val("rst_ps", int'(period_start), 0);
    rst = 1'b0;
    step();
    check_val("rel_ps", int'(period_start), 1);
    check_val("rel_lo", int'(pwm_lo), 3);
    check_val("rel_hi", int'(pwm_hi), 0);

    // edge, duty0=5, duty1=0, D=0
    wr_duty(0, 5);
    align(); align(); clr(); steps(16);
    check_val("e5_hi0", a_hi[0], 5);
    check_val("e5_lo0", a_lo[0], 11);
    check_val("e5_bl0", a_bl[0], 0);
    check_val("e5_hi1", a_hi[1], 0);
    check_val("e5_lo1", a_lo[1], 16);
    check_val("e5_ps", a_ps, 1);

    // duty 0 and full scale
    wr_duty(0, 0); wr_duty(1, 15);
    align(); align(); clr(); steps(16);
    check_val("d0_hi0", a_hi[0], 0);
    check_val("d0_lo0", a_lo[0], 16);
    check_val("d15_hi1", a_hi[1], 15);
    check_val("d15_lo1", a_lo[1], 1);

    // duty 3 -> 9 written mid-period
    wr_duty(0, 3);
    align(); align(); clr(); steps(16);
    check_val("d3_hi0", a_hi[0], 3);
    check_val("d3_end_ps", int'(last_ps), 1);
    clr(); steps(4); wr_duty(0, 9); steps(11);
    check_val("wr_mid_hi0", a_hi[0], 3);
    check_val("wr_mid_ps", int'(last_ps), 1);
    clr(); steps(16);
    check_val("d9_hi0", a_hi[0], 9);

    // edge, duty=8, D=3; channel 1 at 15 aborts its short DT_LO
    dead_time_in = 3'd3;
    wr_duty(0, 8);
    align(); align(); clr(); steps(16);
    check_val("dt3_hi0", a_hi[0], 5);
    check_val("dt3_lo0", a_lo[0], 5);
    check_val("dt3_bl0", a_bl[0], 6);
    check_val("dt3_hi1", a_hi[1], 15);
    check_val("dt3_lo1", a_lo[1], 0);
    check_val("dt3_bl1", a_bl[1], 1);

    // center, duty=4, D=0
    center_in = 1'b1; dead_time_in = 3'd0;
    wr_duty(0, 4);
    align(); align(); clr(); steps(30);
    check_val("c4_hi0", a_hi[0], 7);
    check_val("c4_lo0", a_lo[0], 23);
    check_val("c4_ps", a_ps, 1);
    check_val("c4_end_ps", int'(last_ps), 1);
    check_val("c4_hi1", a_hi[1], 29);
    check_val("c4_lo1", a_lo[1], 1);

    // edge, D=5, duty=1: DT_HI aborts, high side never driven
    center_in = 1'b0; dead_time_in = 3'd5;
    wr_duty(0, 1);
    align(); align(); clr(); steps(16);
    check_val("ab_hi0", a_hi[0], 0);
    check_val("ab_lo0", a_lo[0], 15);
    check_val("ab_bl0", a_bl[0], 1);
    check_val("ab_hi1", a_hi[1], 15);
    check_val("ab_lo1", a_lo[1], 0);

    // reset mid-period
    steps(5);
    rst = 1'b1;
    step();
    check_val("mid_rst_hi", int'(pwm_hi), 0);
    check_val("mid_rst_lo", int'(pwm_lo), 0);
    check_val("mid_rst_ps", int'(period_start), 0);
    step();
    rst = 1'b0;
    step();
    check_val("mid_rel_ps", int'(period_start), 1);
    check_val("mid_rel_lo", int'(pwm_lo), 3);
    align(); align(); clr(); steps(16);
    check_val("post_rst_hi0", a_hi[0], 0);
    check_val("post_rst_hi1", a_hi[1], 0);
    check_val("post_rst_lo0", a_lo[0], 16);

    check_val("never_both_hi", n_both_hi, 0);
    @(negedge clk);
    #1;
    check_val("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
